// File: rtl/cdc_mutex_arbiter_pkg.sv
// cdc_mutex_arbiter_pkg: shared state encoding and counter sizing for the mutex arbiter
package cdc_mutex_arbiter_pkg;
  typedef enum logic [2:0] {WAIT_LOCK, IDLE, GRANT, RELEASE, DRAIN} arb_state_t;
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction
endpackage

// File: rtl/cdc_mutex_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first request at or after ptr
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          valid
);
  always_comb begin
    idx = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (req[j]) idx = IW'(j);
    end
    pick = valid ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
  end
endmodule

// File: rtl/cdc_mutex_arbiter.sv
// cdc_mutex_arbiter: shares a held CDC mutex among local requesters and hands it back on idle or quota
module cdc_mutex_arbiter
  import cdc_mutex_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int IDLE_TIMEOUT = 16,
  parameter int MAX_GRANTS   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] done_i,
  output logic [NUM_REQ-1:0] grant_o,
  input  logic               mutexLocked_i,
  output logic               mutexRelease_o,
  output logic               lockLost_o
);
  localparam int IW  = $clog2(NUM_REQ);
  localparam int IDW = cnt_w(IDLE_TIMEOUT);
  localparam int GCW = cnt_w(MAX_GRANTS);
  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               release_q, release_d;
  logic               lost_q, lost_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IDW-1:0]     idle_q, idle_d;
  logic [GCW-1:0]     gcnt_q, gcnt_d;
  logic [NUM_REQ-1:0] pick;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req  (req_i),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    release_d = 1'b0;
    lost_d = 1'b0;
    ptr_d = ptr_q;
    gidx_d = gidx_q;
    idle_d = idle_q;
    gcnt_d = gcnt_q;
    case (state_q)
      WAIT_LOCK: begin
        grant_d = '0;
        idle_d = '0;
        gcnt_d = '0;
        if (mutexLocked_i) state_d = IDLE;
      end
      IDLE: begin
        if (!mutexLocked_i) state_d = WAIT_LOCK;
        else if (MAX_GRANTS != 0 && gcnt_q == GCW'(MAX_GRANTS)) begin
          state_d = RELEASE;
          release_d = 1'b1;
        end else if (pick_valid) begin
          grant_d = pick;
          gidx_d = pick_idx;
          idle_d = '0;
          state_d = GRANT;
        end else if (IDLE_TIMEOUT != 0 && idle_q == IDW'(IDLE_TIMEOUT)) begin
          state_d = RELEASE;
          release_d = 1'b1;
        end else idle_d = (&idle_q) ? idle_q : idle_q + IDW'(1);
      end
      GRANT: begin
        idle_d = '0;
        if (!mutexLocked_i) begin
          state_d = WAIT_LOCK;
          grant_d = '0;
          lost_d = 1'b1;
        end else if (done_i[gidx_q]) begin
          grant_d = '0;
          ptr_d = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);
          gcnt_d = (&gcnt_q) ? gcnt_q : gcnt_q + GCW'(1);
          state_d = IDLE;
        end
      end
      RELEASE: state_d = DRAIN;
      DRAIN: if (!mutexLocked_i) state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WAIT_LOCK;
      grant_q <= '0;
      release_q <= 1'b0;
      lost_q <= 1'b0;
      ptr_q <= '0;
      gidx_q <= '0;
      idle_q <= '0;
      gcnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      release_q <= release_d;
      lost_q <= lost_d;
      ptr_q <= ptr_d;
      gidx_q <= gidx_d;
      idle_q <= idle_d;
      gcnt_q <= gcnt_d;
    end
  end

  assign grant_o = grant_q;
  assign mutexRelease_o = release_q;
  assign lockLost_o = lost_q;
endmodule

// File: tb/tb_cdc_mutex_arbiter.sv
// tb_cdc_mutex_arbiter: directed checks of idle release, round-robin, quota release, lock loss and reset
module tb_cdc_mutex_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req_a, done_a, grant_a, req_b, done_b, grant_b;
  logic lock_a, rel_a, lost_a, lock_b, rel_b, lost_b;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cdc_mutex_arbiter #(.NUM_REQ(4), .IDLE_TIMEOUT(16), .MAX_GRANTS(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .done_i(done_a), .grant_o(grant_a),
    .mutexLocked_i(lock_a), .mutexRelease_o(rel_a), .lockLost_o(lost_a)
  );

  cdc_mutex_arbiter #(.NUM_REQ(4), .IDLE_TIMEOUT(0), .MAX_GRANTS(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .done_i(done_b), .grant_o(grant_b),
    .mutexLocked_i(lock_b), .mutexRelease_o(rel_b), .lockLost_o(lost_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    int rel_cnt, rel_at, bad_grant;
    logic [3:0] seq [4];
    seq[0] = 4'b0010; seq[1] = 4'b1000; seq[2] = 4'b0010; seq[3] = 4'b1000;
    rst = 1'b1;
    lock_a = 1'b1; req_a = '0; done_a = '0;
    lock_b = 1'b1; req_b = '0; done_b = '0;
    step();
    step();
    chk("rst_grant", 32'(grant_a), 0);
    chk("rst_release", 32'(rel_a), 0);
    chk("rst_lost", 32'(lost_a), 0);
    rst = 1'b0;
    rel_cnt = 0; rel_at = 0; bad_grant = 0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 20) req_a = 4'b1111;
      step();
      if (rel_a) begin rel_cnt++; rel_at = i; end
      if (grant_a != 0) bad_grant++;
    end
    chk("idle_release_count", 32'(rel_cnt), 1);
    chk("idle_release_cycle", 32'(rel_at), 18);
    chk("no_grant_idle_or_drain", 32'(bad_grant), 0);
    req_a = '0;
    lock_a = 1'b0;
    step();
    chk("drop_in_drain_no_lost", 32'(lost_a), 0);
    lock_a = 1'b1;
    step();
    req_a = 4'b1010;
    step();
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rr_grant%0d", g), 32'(grant_a), 32'(seq[g]));
      done_a = ~seq[g];
      step();
      done_a = '0;
      chk($sformatf("rr_hold%0d_ignore_done", g), 32'(grant_a), 32'(seq[g]));
      step();
      chk($sformatf("rr_hold%0d", g), 32'(grant_a), 32'(seq[g]));
      done_a = seq[g];
      step();
      done_a = '0;
      chk($sformatf("rr_clear%0d", g), 32'(grant_a), 0);
      if (g == 3) req_a = '0;
      step();
    end
    chk("rr_no_regrant", 32'(grant_a), 0);
    req_a = 4'b0100;
    step();
    chk("lost_grant_setup", 32'(grant_a), 32'h4);
    req_a = '0;
    step();
    chk("grant_survives_req_drop", 32'(grant_a), 32'h4);
    lock_a = 1'b0;
    step();
    chk("lost_pulse", 32'(lost_a), 1);
    chk("lost_grant_cleared", 32'(grant_a), 0);
    chk("lost_no_release", 32'(rel_a), 0);
    step();
    chk("lost_single_pulse", 32'(lost_a), 0);
    lock_a = 1'b1;
    req_b = 4'b1111;
    step();
    chk("quota_grant0", 32'(grant_b), 32'h1);
    done_b = 4'b0001;
    step();
    done_b = '0;
    chk("quota_clear0", 32'(grant_b), 0);
    step();
    chk("quota_grant1", 32'(grant_b), 32'h2);
    done_b = 4'b0010;
    step();
    done_b = '0;
    chk("quota_clear1", 32'(grant_b), 0);
    step();
    chk("quota_release", 32'(rel_b), 1);
    chk("quota_release_no_grant", 32'(grant_b), 0);
    lock_b = 1'b0;
    step();
    chk("quota_release_one_cycle", 32'(rel_b), 0);
    step();
    step();
    step();
    chk("quota_no_grant_unlocked", 32'(grant_b), 0);
    lock_b = 1'b1;
    step();
    chk("relock_idle_no_grant", 32'(grant_b), 0);
    step();
    chk("relock_grant_bit2", 32'(grant_b), 32'h4);
    rst = 1'b1;
    step();
    chk("rst_mid_grant", 32'(grant_b), 0);
    chk("rst_mid_release", 32'(rel_b), 0);
    chk("rst_mid_lost", 32'(lost_b), 0);
    rst = 1'b0;
    req_b = '0;
    rel_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rel_b) rel_cnt++;
    end
    chk("no_idle_release_timeout0", 32'(rel_cnt), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
